// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// The slave modport is the queue; the master modport is the fetch/decode side.
interface instr_fetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_pc;
  logic [DATA_WIDTH-1:0]   in_instr;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_pc;
  logic [DATA_WIDTH-1:0]   out_instr;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetch FIFO of {pc, instr} pairs between fetch and decode, show-ahead read,
// whole-queue discard on a taken branch/jump flush.
module instr_fetch_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_queue_if.slave  q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         cnt;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Flush and reset mask both handshakes so no transfer can race the discard.
  assign q.in_ready  = !full  && !q.flush && !rst;
  assign q.out_valid = !empty && !q.flush && !rst;

  assign push = q.in_valid  && q.in_ready;
  assign pop  = q.out_valid && q.out_ready;

  assign q.out_pc    = q.out_valid ? pc_mem[rd_ptr]    : '0;
  assign q.out_instr = q.out_valid ? instr_mem[rd_ptr] : '0;
  assign q.count     = cnt;

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= q.in_pc;
      instr_mem[wr_ptr] <= q.in_instr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_instr_fetch_queue;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   live;

  instr_fetch_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } pair_t;

  pair_t mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain list of held pairs, updated at each rising edge.
  always @(posedge clk) begin
    int  sz;
    bit  do_push;
    bit  do_pop;
    pair_t p;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      live = 1'b1;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      do_pop  = (sz > 0) && bus.out_ready;
      do_push = bus.in_valid && (sz < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        p.pc    = bus.in_pc;
        p.instr = bus.in_instr;
        mq.push_back(p);
      end
    end
  end

  // Per-cycle comparison, taken on the falling edge while inputs are stable.
  always @(negedge clk) begin
    logic          e_in_ready;
    logic          e_out_valid;
    logic [DW-1:0] e_pc;
    logic [DW-1:0] e_instr;
    if (live) begin
      e_in_ready  = (mq.size() != DEPTH) && !bus.flush && !rst;
      e_out_valid = (mq.size() != 0) && !bus.flush && !rst;
      e_pc        = e_out_valid ? mq[0].pc    : '0;
      e_instr     = e_out_valid ? mq[0].instr : '0;
      check("model_in_ready",  32'(bus.in_ready),  32'(e_in_ready));
      check("model_out_valid", 32'(bus.out_valid), 32'(e_out_valid));
      check("model_out_pc",    bus.out_pc,         e_pc);
      check("model_out_instr", bus.out_instr,      e_instr);
      check("model_count",     32'(bus.count),     32'(mq.size()));
    end
  end

  task automatic apply(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                       input logic fl, input logic ordy, input logic r);
    #1;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.flush     = fl;
    bus.out_ready = ordy;
    rst           = r;
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                      input logic fl, input logic ordy, input logic r);
    apply(v, pc, ins, fl, ordy, r);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    live          = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset_count",     32'(bus.count),     32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_pc",    bus.out_pc,         32'h0);

    // First push shows up after one edge
    tick(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
    check("first_out_valid", 32'(bus.out_valid), 32'd1);
    check("first_out_pc",    bus.out_pc,         32'h0);
    check("first_out_instr", bus.out_instr,      32'h0050_0093);
    check("first_count",     32'(bus.count),     32'd1);

    // Fill to full, then a fifth in_valid must be ignored
    for (int unsigned i = 1; i < 4; i++)
      tick(1'b1, 32'(4 * i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    check("full_count",    32'(bus.count),    32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick(1'b1, 32'h10, 32'h1010, 1'b0, 1'b0, 1'b0);
    check("full_ignore_count", 32'(bus.count), 32'd4);
    check("full_ignore_pc",    bus.out_pc,     32'h0);

    // Drain in order
    for (int unsigned i = 0; i < 4; i++) begin
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      #2;
      check("drain_pc", bus.out_pc, 32'(4 * i));
      @(negedge clk);
    end
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_count",     32'(bus.count),     32'd0);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("empty_pop_count", 32'(bus.count), 32'd0);

    // Streaming push+pop through five pointer wraps
    for (int unsigned i = 0; i < 20; i++) begin
      tick(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b1, 1'b0);
      check("stream_count", 32'(bus.count), 32'd1);
      check("stream_pc",    bus.out_pc,     32'h100 + 32'(4 * i));
    end
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("stream_drain_count", 32'(bus.count), 32'd0);

    // Flush with three entries held and a push attempt in the same cycle
    for (int unsigned i = 0; i < 3; i++)
      tick(1'b1, 32'h20 + 32'(4 * i), 32'hB000 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("pre_flush_count", 32'(bus.count), 32'd3);
    apply(1'b1, 32'h2C, 32'hB003, 1'b1, 1'b0, 1'b0);
    #2;
    check("flush_in_ready",  32'(bus.in_ready),  32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("post_flush_count", 32'(bus.count), 32'd0);
    tick(1'b1, 32'h40, 32'hC040, 1'b0, 1'b0, 1'b0);
    check("post_flush_pc",    bus.out_pc,     32'h40);
    check("post_flush_instr", bus.out_instr,  32'hC040);
    check("post_flush_cnt",   32'(bus.count), 32'd1);

    // Mid-stream reset with two entries held
    tick(1'b1, 32'h44, 32'hC044, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd2);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_high_in_ready", 32'(bus.in_ready), 32'd0);
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc",    bus.out_pc,         32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    tick(1'b1, 32'h80, 32'hD080, 1'b0, 1'b0, 1'b0);
    check("after_rst_pc", bus.out_pc, 32'h80);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
